sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: RAM storage, pointers, occupancy, programmable almost flags,
// sticky overflow/underflow and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = 64,
  parameter int ADDR_BITS     = $clog2(MEM_DEPTH),
  parameter int AFULL_THRESH  = MEM_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_BITS:0]    o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [ADDR_BITS:0] ONE      = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0] ZERO     = '0;
  localparam logic [ADDR_BITS:0] DEPTH_W  = (ADDR_BITS+1)'(MEM_DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_W  = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] AEMPTY_W = (ADDR_BITS+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_BITS:0]    wr_ptr;
  logic [ADDR_BITS:0]    rd_ptr;
  logic [ADDR_BITS:0]    count_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;
  logic                  valid_next;
  logic                  empty_next;

  // Acceptance uses this cycle's registered flags; o_count is the total
  // occupancy, so full-by-count also keeps the RAM from overrunning in FWFT mode.
  always_comb begin
    wr_acc     = i_wr_en && !o_full;
    rd_acc     = i_rd_en && !o_empty;
    count_next = o_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = o_count + ONE;
      2'b01:   count_next = o_count - ONE;
      default: count_next = o_count;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Refill the output register whenever it is empty or being popped this cycle.
  always_comb begin
    ram_rd     = (!o_rd_valid || rd_acc) && (wr_ptr != rd_ptr);
    valid_next = ram_rd || (o_rd_valid && !rd_acc);
    empty_next = !valid_next;
  end
`else
  always_comb begin
    ram_rd     = rd_acc;
    valid_next = rd_acc;
    empty_next = (count_next == ZERO);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_reset && !i_flush)
      mem[wr_ptr[ADDR_BITS-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_empty <= 1'b1;
      o_almost_full  <= 1'b0;
      o_rd_valid     <= 1'b0;
      o_rd_data      <= '0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else if (i_flush) begin
      // Flush keeps the last read word visible on o_rd_data.
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_empty <= 1'b1;
      o_almost_full  <= 1'b0;
      o_rd_valid     <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + ONE;
      if (ram_rd) begin
        rd_ptr    <= rd_ptr + ONE;
        o_rd_data <= mem[rd_ptr[ADDR_BITS-1:0]];
      end
      o_count        <= count_next;
      o_full         <= (count_next == DEPTH_W);
      o_empty        <= empty_next;
      o_almost_full  <= (count_next >= AFULL_W);
      o_almost_empty <= (count_next <= AEMPTY_W);
      o_rd_valid     <= valid_next;
      if (i_wr_en && !wr_acc)
        o_overflow <= 1'b1;
      if (i_rd_en && !rd_acc)
        o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (standard mode, MEM_DEPTH=16):
// directed scenarios followed by randomized traffic against a queue-based model.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AB    = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_rd_en = 1'b0;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic [AB:0]   o_count;
  logic          o_overflow;
  logic          o_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a plain queue plus the visible read word.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_udf   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_flush(i_flush),
    .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data),
    .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_almost_full(o_almost_full),
    .o_almost_empty(o_almost_empty),
    .o_count(o_count),
    .o_overflow(o_overflow),
    .o_underflow(o_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    int n;
    n = model_q.size();
    checkOutput("count",        32'(o_count),        32'(n));
    checkOutput("full",         32'(o_full),         32'(n == DEPTH));
    checkOutput("empty",        32'(o_empty),        32'(n == 0));
    checkOutput("almost_full",  32'(o_almost_full),  32'(n >= DEPTH - 4));
    checkOutput("almost_empty", 32'(o_almost_empty), 32'(n <= 4));
    checkOutput("rd_valid",     32'(o_rd_valid),     32'(m_valid));
    checkOutput("rd_data",      32'(o_rd_data),      32'(m_data));
    checkOutput("overflow",     32'(o_overflow),     32'(m_ovf));
    checkOutput("underflow",    32'(o_underflow),    32'(m_udf));
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, check on the falling edge.
  task automatic applyStimulus(input logic rst, input logic flush, input logic wr,
                               input logic [DW-1:0] data, input logic rd);
    logic was_full;
    logic was_empty;
    i_reset   = rst;
    i_flush   = flush;
    i_wr_en   = wr;
    i_wr_data = data;
    i_rd_en   = rd;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else if (flush) begin
      model_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      m_valid   = 1'b0;
      if (rd && !was_empty) begin
        m_data  = model_q.pop_front();
        m_valid = 1'b1;
      end
      if (wr && !was_full)
        model_q.push_back(data);
      if (wr && was_full)
        m_ovf = 1'b1;
      if (rd && was_empty)
        m_udf = 1'b1;
    end
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    int wr_pct;
    int rd_pct;
    $display("[TB] start");

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Fill to full, then reject an extra write
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Drain completely and try one read too many
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset clears sticky flags; simultaneous read+write on empty rejects the read
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Eight stored, then 20 cycles of concurrent traffic wrapping the pointers
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);

    // Flush with a same-cycle write, then confirm fresh data from address 0
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic in phases biased toward filling, draining and balance
    for (int phase = 0; phase < 12; phase++) begin
      case (phase % 3)
        0:       begin wr_pct = 85; rd_pct = 25; end
        1:       begin wr_pct = 25; rd_pct = 85; end
        default: begin wr_pct = 60; rd_pct = 60; end
      endcase
      for (int c = 0; c < 150; c++)
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 79) == 0,
                      $urandom_range(0, 99) < wr_pct,
                      8'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < rd_pct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
